// File: rtl/shift_receiver.sv
// shift_receiver: serial-to-parallel receiver with selectable bit order,
// a one-word output holding register with valid/ready handshake, and a
// sticky overrun flag for completed words that had nowhere to go.
module shift_receiver #(
  parameter int WIDTH = 8
) (
  input  logic                       clock,
  input  logic                       Reset_b,
  input  logic                       start,
  input  logic                       ShiftLeft,
  input  logic                       serial_in,
  input  logic                       bit_valid,
  input  logic                       out_ready,
  input  logic                       clear_err,
  output logic [WIDTH-1:0]           Q,
  output logic                       out_valid,
  output logic                       busy,
  output logic [$clog2(WIDTH+1)-1:0] bit_count,
  output logic                       overrun
);

  localparam int CW = $clog2(WIDTH+1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [CW-1:0]    count_q, count_d;
  logic             dir_q, dir_d;
  logic [WIDTH-1:0] shifted;
  logic             word_done;
  logic             load_word;

  // Frame control: start (re)opens a frame, valid bits shift in, the
  // WIDTH-th bit closes the frame and hands the assembled word onward.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    count_d   = count_q;
    dir_d     = dir_q;
    word_done = 1'b0;
    if (dir_q) begin
      shifted = {shift_q[WIDTH-2:0], serial_in};
    end else begin
      shifted = {serial_in, shift_q[WIDTH-1:1]};
    end
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_d = '0;
          count_d = '0;
          dir_d   = ShiftLeft;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (start) begin
          shift_d = '0;
          count_d = '0;
          dir_d   = ShiftLeft;
        end else if (bit_valid) begin
          shift_d = shifted;
          if (count_q == LAST_BIT) begin
            word_done = 1'b1;
            count_d   = '0;
            state_d   = IDLE;
          end else begin
            count_d = count_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A finished word may take the holding register only if it is empty or
  // being drained on this very edge.
  assign load_word = word_done && (!out_valid || out_ready);

  // Frame state registers.
  always_ff @(posedge clock or negedge Reset_b) begin
    if (!Reset_b) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  // Output holding register and handshake; a new load keeps valid high.
  always_ff @(posedge clock or negedge Reset_b) begin
    if (!Reset_b) begin
      Q         <= '0;
      out_valid <= 1'b0;
    end else if (load_word) begin
      Q         <= shifted;
      out_valid <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Sticky overrun: a dropped word sets it and beats a coincident clear.
  always_ff @(posedge clock or negedge Reset_b) begin
    if (!Reset_b) begin
      overrun <= 1'b0;
    end else if (word_done && out_valid && !out_ready) begin
      overrun <= 1'b1;
    end else if (clear_err) begin
      overrun <= 1'b0;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign bit_count = count_q;

endmodule
